// File: rtl/btn_evt_decoder.sv
// Button event decoder: debounces raw button samples, measures press
// duration in sample ticks and raises sticky short/long press flags.
// Optional feature macro: BTN_EVT_RESET_EN adds the HOLD state and a one-cycle
// rst_req pulse when a hold reaches RST_STB samples.
module btn_evt_decoder #(
    parameter int unsigned DEBOUNCE_N = 4,
    parameter int unsigned LONG_STB   = 500,
    parameter int unsigned RST_STB    = 2500,
    parameter int unsigned DUR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_val,
    input  logic             btn_stb,
    output logic             btn_stable,
    output logic [DUR_W-1:0] press_dur,
    output logic             evt_short,
    output logic             evt_long,
    input  logic [1:0]       evt_clr,
    output logic             rst_req
);

    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] DEB_VAL  = CNT_W'(DEBOUNCE_N);
    localparam logic [DUR_W-1:0] DUR_MAX  = '1;
    localparam logic [DUR_W-1:0] LONG_VAL = DUR_W'(LONG_STB);

    // Elaboration guard: the reset threshold must lie beyond the long threshold.
    if (RST_STB <= LONG_STB) begin : g_cfg_err
        $error("btn_evt_decoder: RST_STB must exceed LONG_STB");
    end

`ifdef BTN_EVT_RESET_EN
    localparam logic [DUR_W-1:0] RST_VAL = DUR_W'(RST_STB);
    typedef enum logic [1:0] {IDLE, PRESS, LONG, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;
`endif

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             stable_dly_q;
    logic             rise_c;
    logic             fall_c;
    logic [DUR_W-1:0] dur_inc_c;
    logic [DUR_W-1:0] dur_d;
    logic             short_d;
    logic             long_d;
    logic             rst_req_d;

    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign rise_c    = btn_stable & ~stable_dly_q;
    assign fall_c    = ~btn_stable & stable_dly_q;
    assign dur_inc_c = (press_dur == DUR_MAX) ? press_dur : press_dur + DUR_W'(1);

    // Debounce: count consecutive strobes that disagree with the stable state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            btn_stable <= 1'b0;
        end else if (btn_stb) begin
            if (btn_val != btn_stable) begin
                if (cnt_inc_c == DEB_VAL) begin
                    btn_stable <= ~btn_stable;
                    cnt_q      <= '0;
                end else begin
                    cnt_q <= cnt_inc_c;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // State and registered outputs; FSM sees debounced edges one cycle late.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            stable_dly_q <= 1'b0;
            press_dur    <= '0;
            evt_short    <= 1'b0;
            evt_long     <= 1'b0;
            rst_req      <= 1'b0;
        end else begin
            state_q      <= state_d;
            stable_dly_q <= btn_stable;
            press_dur    <= dur_d;
            evt_short    <= short_d;
            evt_long     <= long_d;
            rst_req      <= rst_req_d;
        end
    end

    // Next state, duration update and sticky flag logic (set beats clear).
    always_comb begin
        state_d   = state_q;
        dur_d     = press_dur;
        short_d   = evt_short & ~evt_clr[0];
        long_d    = evt_long & ~evt_clr[1];
        rst_req_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d = PRESS;
                    dur_d   = '0;
                end
            end
            PRESS: begin
                if (fall_c) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end else if (btn_stb) begin
                    dur_d = dur_inc_c;
                    if (dur_inc_c == LONG_VAL) begin
                        state_d = LONG;
                        long_d  = 1'b1;
                    end
                end
            end
            LONG: begin
                if (fall_c) begin
                    state_d = IDLE;
                end else if (btn_stb) begin
                    dur_d = dur_inc_c;
`ifdef BTN_EVT_RESET_EN
                    if (dur_inc_c == RST_VAL) begin
                        state_d   = HOLD;
                        rst_req_d = 1'b1;
                    end
`endif
                end
            end
`ifdef BTN_EVT_RESET_EN
            HOLD: begin
                if (fall_c) begin
                    state_d = IDLE;
                end else if (btn_stb) begin
                    dur_d = dur_inc_c;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_btn_evt_decoder.sv
// Directed bench for btn_evt_decoder: a default-parameter instance plus a
// narrow (DUR_W=8) instance sharing the same stimulus for saturation checks.
module tb_btn_evt_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_val;
    logic        btn_stb;
    logic [1:0]  evt_clr;

    logic        btn_stable;
    logic [15:0] press_dur;
    logic        evt_short;
    logic        evt_long;
    logic        rst_req;

    logic        s2_stable;
    logic [7:0]  s2_dur;
    logic        s2_short;
    logic        s2_long;
    logic        s2_rst_req;

    int   checks = 0;
    int   errors = 0;
    int   rst_hi = 0;
    logic rst_at_stb;

    always #5 clk = ~clk;

    btn_evt_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .btn_val    (btn_val),
        .btn_stb    (btn_stb),
        .btn_stable (btn_stable),
        .press_dur  (press_dur),
        .evt_short  (evt_short),
        .evt_long   (evt_long),
        .evt_clr    (evt_clr),
        .rst_req    (rst_req)
    );

    btn_evt_decoder #(
        .DEBOUNCE_N (4),
        .LONG_STB   (100),
        .RST_STB    (200),
        .DUR_W      (8)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .btn_val    (btn_val),
        .btn_stb    (btn_stb),
        .btn_stable (s2_stable),
        .press_dur  (s2_dur),
        .evt_short  (s2_short),
        .evt_long   (s2_long),
        .evt_clr    (evt_clr),
        .rst_req    (s2_rst_req)
    );

    // Count every cycle rst_req is high on the default instance.
    always @(negedge clk) begin
        if (rst_req) rst_hi++;
    end

    // One strobe; rst_at_stb captures rst_req in the cycle right after it.
    task automatic strobe(input logic v, input int gap);
        @(negedge clk);
        btn_val = v;
        btn_stb = 1'b1;
        @(negedge clk);
        btn_stb    = 1'b0;
        rst_at_stb = rst_req;
        repeat (gap) @(negedge clk);
    endtask

    task automatic clear_flags();
        @(negedge clk);
        evt_clr = 2'b11;
        @(negedge clk);
        evt_clr = 2'b00;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        btn_val = 1'b0;
        btn_stb = 1'b0;
        evt_clr = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if (btn_stable !== 1'b0) begin errors++; $display("FAIL reset_stable: got %0b want 0", btn_stable); end
        checks++; if (press_dur !== 16'd0) begin errors++; $display("FAIL reset_dur: got %0d want 0", press_dur); end
        checks++; if (evt_short !== 1'b0) begin errors++; $display("FAIL reset_short: got %0b want 0", evt_short); end
        checks++; if (evt_long !== 1'b0) begin errors++; $display("FAIL reset_long: got %0b want 0", evt_long); end
        checks++; if (rst_req !== 1'b0) begin errors++; $display("FAIL reset_rst_req: got %0b want 0", rst_req); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // 4 debounce strobes, 1000 held strobes, 4 release strobes.
    task automatic test_long_no_reset();
        int rst0;
        rst0 = rst_hi;
        for (int i = 1; i <= 3; i++) strobe(1'b1, 2);
        checks++; if (btn_stable !== 1'b0) begin errors++; $display("FAIL deb_before: got %0b want 0", btn_stable); end
        strobe(1'b1, 0);
        checks++; if (btn_stable !== 1'b1) begin errors++; $display("FAIL deb_rise: got %0b want 1", btn_stable); end
        @(negedge clk);
        for (int i = 1; i <= 1000; i++) begin
            strobe(1'b1, 2);
            if (i == 499) begin
                checks++; if (evt_long !== 1'b0) begin errors++; $display("FAIL long_at499: got %0b want 0", evt_long); end
            end
            if (i == 500) begin
                checks++; if (evt_long !== 1'b1) begin errors++; $display("FAIL long_at500: got %0b want 1", evt_long); end
            end
        end
        checks++; if (press_dur !== 16'd1000) begin errors++; $display("FAIL long_dur_held: got %0d want 1000", press_dur); end
        for (int i = 1; i <= 4; i++) strobe(1'b0, 2);
        checks++; if (btn_stable !== 1'b0) begin errors++; $display("FAIL long_release: got %0b want 0", btn_stable); end
        checks++; if (press_dur !== 16'd1004) begin errors++; $display("FAIL long_dur_final: got %0d want 1004", press_dur); end
        checks++; if (evt_short !== 1'b0) begin errors++; $display("FAIL long_no_short: got %0b want 0", evt_short); end
        checks++; if (evt_long !== 1'b1) begin errors++; $display("FAIL long_sticky: got %0b want 1", evt_long); end
        checks++; if (rst_hi - rst0 !== 0) begin errors++; $display("FAIL long_no_rst_req: got %0d want 0", rst_hi - rst0); end
        clear_flags();
        checks++; if (evt_long !== 1'b0) begin errors++; $display("FAIL long_clear: got %0b want 0", evt_long); end
    endtask

    // 96 held strobes plus 4 release strobes that still count: 100 total.
    task automatic test_short_press();
        for (int i = 1; i <= 4; i++) strobe(1'b1, 2);
        for (int i = 1; i <= 96; i++) strobe(1'b1, 2);
        for (int i = 1; i <= 4; i++) strobe(1'b0, 2);
        checks++; if (evt_short !== 1'b1) begin errors++; $display("FAIL short_flag: got %0b want 1", evt_short); end
        checks++; if (evt_long !== 1'b0) begin errors++; $display("FAIL short_no_long: got %0b want 0", evt_long); end
        checks++; if (press_dur !== 16'd100) begin errors++; $display("FAIL short_dur: got %0d want 100", press_dur); end
        repeat (5) @(negedge clk);
        checks++; if (press_dur !== 16'd100) begin errors++; $display("FAIL short_dur_hold: got %0d want 100", press_dur); end
        clear_flags();
        checks++; if (evt_short !== 1'b0) begin errors++; $display("FAIL short_clear: got %0b want 0", evt_short); end
    endtask

    task automatic test_glitch();
        for (int g = 1; g <= 3; g++) begin
            for (int k = 0; k < g; k++) begin
                strobe(1'b1, 2);
                checks++; if (btn_stable !== 1'b0) begin errors++; $display("FAIL glitch%0d_stable: got %0b want 0", g, btn_stable); end
            end
            strobe(1'b0, 2);
            strobe(1'b0, 2);
            checks++; if (btn_stable !== 1'b0) begin errors++; $display("FAIL glitch%0d_after: got %0b want 0", g, btn_stable); end
            checks++; if (press_dur !== 16'd100) begin errors++; $display("FAIL glitch%0d_dur: got %0d want 100", g, press_dur); end
            checks++; if ({evt_short, evt_long} !== 2'b00) begin errors++; $display("FAIL glitch%0d_flags: got %02b want 00", g, {evt_short, evt_long}); end
        end
    endtask

    // Clear arrives in the very cycle evt_short is being set; set must win.
    task automatic test_clear_race();
        for (int i = 1; i <= 4; i++) strobe(1'b1, 2);
        for (int i = 1; i <= 10; i++) strobe(1'b1, 2);
        for (int i = 1; i <= 3; i++) strobe(1'b0, 2);
        strobe(1'b0, 0);
        checks++; if (evt_short !== 1'b0) begin errors++; $display("FAIL race_pre: got %0b want 0", evt_short); end
        evt_clr = 2'b01;
        @(negedge clk);
        checks++; if (evt_short !== 1'b1) begin errors++; $display("FAIL race_set_wins: got %0b want 1", evt_short); end
        @(negedge clk);
        checks++; if (evt_short !== 1'b0) begin errors++; $display("FAIL race_clear_later: got %0b want 0", evt_short); end
        evt_clr = 2'b00;
        checks++; if (press_dur !== 16'd14) begin errors++; $display("FAIL race_dur: got %0d want 14", press_dur); end
    endtask

    task automatic test_reset_hold();
        int rst0;
        int rst_idx;
        rst0    = rst_hi;
        rst_idx = -1;
        for (int i = 1; i <= 4; i++) strobe(1'b1, 2);
        for (int i = 1; i <= 3000; i++) begin
            strobe(1'b1, 2);
            if (rst_at_stb) rst_idx = i;
        end
`ifdef BTN_EVT_RESET_EN
        checks++; if (rst_hi - rst0 !== 1) begin errors++; $display("FAIL hold_rst_cycles: got %0d want 1", rst_hi - rst0); end
        checks++; if (rst_idx !== 2500) begin errors++; $display("FAIL hold_rst_strobe: got %0d want 2500", rst_idx); end
`else
        checks++; if (rst_hi - rst0 !== 0) begin errors++; $display("FAIL hold_rst_cycles: got %0d want 0", rst_hi - rst0); end
        checks++; if (rst_idx !== -1) begin errors++; $display("FAIL hold_rst_strobe: got %0d want -1", rst_idx); end
`endif
        checks++; if (evt_long !== 1'b1) begin errors++; $display("FAIL hold_long: got %0b want 1", evt_long); end
        for (int i = 1; i <= 4; i++) strobe(1'b0, 2);
        checks++; if (evt_short !== 1'b0) begin errors++; $display("FAIL hold_no_short: got %0b want 0", evt_short); end
        clear_flags();
    endtask

    task automatic test_saturation();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) strobe(1'b1, 2);
        for (int i = 1; i <= 400; i++) begin
            strobe(1'b1, 2);
            if (i == 254) begin
                checks++; if (s2_dur !== 8'd254) begin errors++; $display("FAIL sat_at254: got %0d want 254", s2_dur); end
            end
            if (i == 255) begin
                checks++; if (s2_dur !== 8'd255) begin errors++; $display("FAIL sat_at255: got %0d want 255", s2_dur); end
            end
        end
        checks++; if (s2_dur !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d want 255", s2_dur); end
        checks++; if (s2_long !== 1'b1) begin errors++; $display("FAIL sat_long: got %0b want 1", s2_long); end
        checks++; if (press_dur !== 16'd400) begin errors++; $display("FAIL sat_wide_dur: got %0d want 400", press_dur); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({s2_stable, s2_short, s2_long, s2_rst_req} !== 4'b0000) begin errors++; $display("FAIL midrst_bits: got %04b want 0000", {s2_stable, s2_short, s2_long, s2_rst_req}); end
        checks++; if (s2_dur !== 8'd0) begin errors++; $display("FAIL midrst_dur: got %0d want 0", s2_dur); end
        checks++; if ({btn_stable, evt_long} !== 2'b00 || press_dur !== 16'd0) begin errors++; $display("FAIL midrst_wide: got stable %0b long %0b dur %0d want 0 0 0", btn_stable, evt_long, press_dur); end
        for (int i = 1; i <= 4; i++) strobe(1'b1, 2);
        checks++; if (s2_stable !== 1'b1) begin errors++; $display("FAIL repress_stable: got %0b want 1", s2_stable); end
        for (int i = 1; i <= 5; i++) strobe(1'b1, 2);
        checks++; if (s2_dur !== 8'd5) begin errors++; $display("FAIL repress_dur: got %0d want 5", s2_dur); end
        for (int i = 1; i <= 4; i++) strobe(1'b0, 2);
        checks++; if (s2_dur !== 8'd9 || s2_short !== 1'b1) begin errors++; $display("FAIL repress_short: got dur %0d short %0b want 9 1", s2_dur, s2_short); end
    endtask

    initial begin
        test_reset();
        test_long_no_reset();
        test_short_press();
        test_glitch();
        test_clear_race();
        test_reset_hold();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_evt_decoder.md
# btn_evt_decoder

Button event decoder sitting directly downstream of the shared-SPI LED/button interface. It consumes the raw periodic button samples (`btn_val` qualified by `btn_stb`), debounces them and measures press duration in sample ticks. It classifies each press as short or long and presents sticky pending-event flags to the `misc` register block. Optionally it raises a system reset request on a very long hold.

## Interface

Parameters:
- `DEBOUNCE_N`, 4: consecutive identical samples required to change the debounced state; range 1..15.
- `LONG_STB`, 500: press duration in samples at which a press becomes "long".
- `RST_STB`, 2500: hold duration in samples that triggers `rst_req`; must exceed `LONG_STB`.
- `DUR_W`, 16: width of the duration counter.

Ports:
- `clk` in 1: system clock (`clk_sys`).
- `rst` in 1: synchronous, active-high reset.
- `btn_val` in 1: raw button sample, 1 = pressed; valid only when `btn_stb` is high.
- `btn_stb` in 1: one-cycle sample strobe.
- `btn_stable` out 1: debounced button state.
- `press_dur` out DUR_W: duration of the last completed press, or of the current press while held; saturating.
- `evt_short` out 1: sticky flag, short press completed.
- `evt_long` out 1: sticky flag, long press reached.
- `evt_clr` in 2: one-cycle clear; bit0 clears `evt_short`, bit1 clears `evt_long`.
- `rst_req` out 1: one-cycle reset request pulse.

## Operation

- **Debounce:**
  - The `cnt` register has 4 bits.
  - On each `btn_stb`:
    - If `btn_val != btn_stable`, increment `cnt`.
    - Otherwise clear `cnt`.
  - When the increment would make `cnt == DEBOUNCE_N`, toggle `btn_stable` and clear `cnt`.
  - Cycles without `btn_stb` change nothing.
- **FSM states:** IDLE, PRESS, LONG, HOLD.
  - IDLE → PRESS on the rising edge of `btn_stable`. On entry, `press_dur` is loaded with 0.
  - PRESS:
    - Each `btn_stb` increments `press_dur`.
    - If the incremented value == `LONG_STB`, go to LONG and set `evt_long`.
    - On the falling edge of `btn_stable`, set `evt_short` and go to IDLE.
  - LONG:
    - `press_dur` continues to increment.
    - If the incremented value == `RST_STB`, pulse `rst_req` and go to HOLD (only when `BTN_EVT_RESET_EN` is defined).
    - On the falling edge of `btn_stable`, go to IDLE with no `evt_short`.
  - HOLD: `press_dur` saturates at all-ones; the FSM goes to IDLE on the falling edge of `btn_stable`.
- `press_dur` saturates at `2**DUR_W-1` in every state and never wraps. It holds its value in IDLE until the next press.
- **Sticky flags:** set by events, cleared by the matching `evt_clr` bit. If set and clear occur in the same cycle, set wins.
- The debounce and duration updates triggered by the same `btn_stb` are evaluated on that strobe's cycle. The FSM reacts to the `btn_stable` edge one cycle later.

## Timing

- **Reset values:**
  - `btn_stable` = 0, `cnt` = 0, `press_dur` = 0.
  - `evt_short` = 0, `evt_long` = 0, `rst_req` = 0.
  - FSM = IDLE.
- `btn_stable` changes in the cycle after the DEBOUNCE_N-th consistent strobe.
- FSM transition, flag set and `rst_req` pulse appear one cycle after the causing `btn_stable` edge or strobe.
- `rst_req` is exactly one cycle high.
- Reset asserted mid-press returns every register to its reset value. The button still being held after reset is treated as a new press once debounced.
- A glitch shorter than `DEBOUNCE_N` strobes is invisible at every output.

## Configuration

- **Macro `BTN_EVT_RESET_EN`:**
  - Defined: the LONG → HOLD transition exists and `rst_req` pulses once per hold reaching `RST_STB`.
  - Undefined:
    - `rst_req` is tied to 0.
    - The HOLD state and the `RST_STB` comparator are removed.
    - LONG saturates `press_dur` itself.

## Test plan

- **Debounce, long flag, no reset:** `DEBOUNCE_N`=4; drive `btn_val`=1 on 4 strobes, then 1000 more strobes, then 4 strobes of 0.
  - `btn_stable` rises the cycle after strobe 4.
  - `evt_long` sets once; `evt_short` stays 0.
  - `rst_req` never pulses.
- **Short press:** press held 100 strobes, then released → `evt_short`=1, `evt_long`=0, `press_dur`=100 after release.
- **Glitch rejection:** glitches of 1, 2 and 3 consecutive pressed samples among released samples → `btn_stable`, flags and `press_dur` all unchanged.
- **Reset hold:** with `BTN_EVT_RESET_EN`, hold for 3000 strobes → single one-cycle `rst_req` at strobe 2500 past debounce, `evt_long`=1. Without the macro, `rst_req` stays 0 throughout.
- **Clear race:** `evt_clr`=2'b01 in the same cycle `evt_short` sets → flag reads 1. A clear one cycle later → flag reads 0.
- **Saturation and mid-press reset:** `DUR_W`=8, `LONG_STB`=100, hold 400 strobes → `press_dur` saturates at 255. Assert `rst` mid-hold → all outputs 0 the next cycle.
